// File: rtl/decode_pkg.sv
// decode_pkg: shared decode definitions for decode_stage.
//   - RV32 major opcode constants
//   - ctrl_t: 15-bit control bundle, MSB->LSB
//     reg_write, imm_src[2:0], alu_src, mem_write, result_src[2:0],
//     branch_op[1:0], alu_op[1:0], width_op, pc_base_src
//   - field-value constants and CTRL_NOP (all zero)
package decode_pkg;

  localparam int CTRL_W = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] result_src;
    logic [1:0] branch_op;
    logic [1:0] alu_op;
    logic       width_op;
    logic       pc_base_src;
  } ctrl_t;

  // immediate extension format
  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_S = 3'd1;
  localparam logic [2:0] EXT_B = 3'd2;
  localparam logic [2:0] EXT_J = 3'd3;
  localparam logic [2:0] EXT_U = 3'd4;

  // writeback source
  localparam logic [2:0] RES_ALU   = 3'd0;
  localparam logic [2:0] RES_MEM   = 3'd1;
  localparam logic [2:0] RES_PC4   = 3'd2;
  localparam logic [2:0] RES_IMM   = 3'd3;
  localparam logic [2:0] RES_PCIMM = 3'd4;

  // control-flow kind
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JAL  = 2'd2;
  localparam logic [1:0] BR_JALR = 2'd3;

  // ALU operation class (funct3/funct7 resolved in EX)
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_RTYPE = 2'd2;
  localparam logic [1:0] ALU_ITYPE = 2'd3;

  // memory access width: fixed word or taken from funct3
  localparam logic WID_NONE = 1'b0;
  localparam logic WID_F3   = 1'b1;

  // jump target base
  localparam logic PCB_PC  = 1'b0;
  localparam logic PCB_RS1 = 1'b1;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode_lane.sv
// ctrl_decode_lane: combinational single-lane decoder.
//   instr_i   [31:0]  raw instruction
//   ctrl_o    ctrl_t  control bundle (CTRL_NOP when illegal)
//   illegal_o         unknown opcode, low bits != 2'b11, or FENCE when unsupported
module ctrl_decode_lane
  import decode_pkg::*;
#(
  parameter int SUPPORT_FENCE = 1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  // only the major opcode steers the bundle; the rest is decoded in EX
  logic unused_hi;
  assign unused_hi = ^instr_i[31:7];

  always_comb begin
    ctrl_o    = CTRL_NOP;
    illegal_o = 1'b0;
    // every legal opcode below has [1:0]=2'b11, so compressed encodings
    // fall through to default
    case (instr_i[6:0])
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      OP_I_ALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_src   = EXT_I;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ITYPE;
      end
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = EXT_I;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.width_op   = WID_F3;
      end
      OP_STORE: begin
        ctrl_o.imm_src   = EXT_S;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.width_op  = WID_F3;
      end
      OP_BRANCH: begin
        ctrl_o.imm_src   = EXT_B;
        ctrl_o.branch_op = BR_COND;
        ctrl_o.alu_op    = ALU_SUB;
      end
      OP_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = EXT_J;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.branch_op  = BR_JAL;
      end
      OP_JALR: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.imm_src     = EXT_I;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.result_src  = RES_PC4;
        ctrl_o.branch_op   = BR_JALR;
        ctrl_o.pc_base_src = PCB_RS1;
      end
      OP_LUI: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = EXT_U;
        ctrl_o.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = EXT_U;
        ctrl_o.result_src = RES_PCIMM;
      end
      OP_FENCE: illegal_o = (SUPPORT_FENCE == 0);
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered LANES-wide decode with a 2-entry skid buffer.
//   clk_i, reset_n_i (async, active low), flush_i
//   in_valid_i / in_ready_o / instr_i[32*LANES]     upstream handshake
//   dec_valid_o / dec_ready_i / ctrl_o[15*LANES],   downstream handshake
//   illegal_o[LANES]
//   illegal_cnt_o[CNT_W]  saturating count of illegal lanes drained
// in_ready_o comes only from skid occupancy, so there is no combinational
// path from dec_ready_i back to upstream.
module decode_stage
  import decode_pkg::*;
#(
  parameter int LANES         = 1,
  parameter int SUPPORT_FENCE = 1,
  parameter int CNT_W         = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [32*LANES-1:0]       instr_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [CTRL_W*LANES-1:0]   ctrl_o,
  output logic [LANES-1:0]          illegal_o,
  output logic [CNT_W-1:0]          illegal_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t [LANES-1:0] dec_ctrl;
  logic  [LANES-1:0] dec_ill;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ctrl_decode_lane #(.SUPPORT_FENCE(SUPPORT_FENCE)) u_lane (
      .instr_i   (instr_i[32*g +: 32]),
      .ctrl_o    (dec_ctrl[g]),
      .illegal_o (dec_ill[g])
    );
  end

  logic              main_valid_q, skid_valid_q;
  ctrl_t [LANES-1:0] main_ctrl_q,  skid_ctrl_q;
  logic  [LANES-1:0] main_ill_q,   skid_ill_q;
  logic  [CNT_W-1:0] cnt_q;

  logic accept, drain;
  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && in_ready_o;
  assign drain      = main_valid_q && dec_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_ill_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_ill_q   <= '0;
    end else if (flush_i) begin
      // flush beats any same-cycle accept
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_ill_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_ill_q   <= '0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // skid full means in_ready_o=0, so no accept competes here
        main_ctrl_q  <= skid_ctrl_q;
        main_ill_q   <= skid_ill_q;
        skid_valid_q <= 1'b0;
        skid_ctrl_q  <= '0;
        skid_ill_q   <= '0;
      end else if (accept) begin
        main_ctrl_q <= dec_ctrl;
        main_ill_q  <= dec_ill;
      end else begin
        main_valid_q <= 1'b0;
        main_ctrl_q  <= '0;
        main_ill_q   <= '0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_q <= 1'b1;
        main_ctrl_q  <= dec_ctrl;
        main_ill_q   <= dec_ill;
      end else begin
        skid_valid_q <= 1'b1;
        skid_ctrl_q  <= dec_ctrl;
        skid_ill_q   <= dec_ill;
      end
    end
  end

  // popcount of illegal lanes in the group being delivered (LANES <= 4)
  logic [2:0]       pop;
  logic [CNT_W+2:0] cnt_sum;
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + 3'(main_ill_q[i]);
    cnt_sum = {3'b000, cnt_q} + {{CNT_W{1'b0}}, pop};
  end

  // counts drains even in a flush cycle; flush never clears it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      cnt_q <= '0;
    else if (drain)
      cnt_q <= (cnt_sum > {3'b000, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  assign dec_valid_o   = main_valid_q;
  assign ctrl_o        = main_ctrl_q;
  assign illegal_o     = main_ill_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Two DUTs share all inputs: A (LANES=2, FENCE decoded, CNT_W=8) and
// B (LANES=2, FENCE illegal, CNT_W=2). Reference model: a 2-deep queue of
// raw instruction groups plus an opcode->bundle table.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        dec_ready = 1'b0;
  logic [63:0] instr = '0;

  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [29:0] ctrl_a, ctrl_b;
  logic [1:0]  ill_a, ill_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  decode_stage #(.LANES(2), .SUPPORT_FENCE(1), .CNT_W(8)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy_a), .instr_i(instr),
    .dec_valid_o(vld_a), .dec_ready_i(dec_ready),
    .ctrl_o(ctrl_a), .illegal_o(ill_a), .illegal_cnt_o(cnt_a)
  );

  decode_stage #(.LANES(2), .SUPPORT_FENCE(0), .CNT_W(2)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy_b), .instr_i(instr),
    .dec_valid_o(vld_b), .dec_ready_i(dec_ready),
    .ctrl_o(ctrl_b), .illegal_o(ill_b), .illegal_cnt_o(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q[$];
  int m_cnt_a = 0;
  int m_cnt_b = 0;

  // {illegal, bundle} for one instruction
  function automatic logic [15:0] ref_dec(input logic [31:0] ins, input bit fence);
    case (ins[6:0])
      OP_R:      return {1'b0, 1'b1, EXT_I, 1'b0, 1'b0, RES_ALU,   BR_NONE, ALU_RTYPE, 1'b0, 1'b0};
      OP_I_ALU:  return {1'b0, 1'b1, EXT_I, 1'b1, 1'b0, RES_ALU,   BR_NONE, ALU_ITYPE, 1'b0, 1'b0};
      OP_LOAD:   return {1'b0, 1'b1, EXT_I, 1'b1, 1'b0, RES_MEM,   BR_NONE, ALU_ADD,   1'b1, 1'b0};
      OP_STORE:  return {1'b0, 1'b0, EXT_S, 1'b1, 1'b1, RES_ALU,   BR_NONE, ALU_ADD,   1'b1, 1'b0};
      OP_BRANCH: return {1'b0, 1'b0, EXT_B, 1'b0, 1'b0, RES_ALU,   BR_COND, ALU_SUB,   1'b0, 1'b0};
      OP_JAL:    return {1'b0, 1'b1, EXT_J, 1'b0, 1'b0, RES_PC4,   BR_JAL,  ALU_ADD,   1'b0, 1'b0};
      OP_JALR:   return {1'b0, 1'b1, EXT_I, 1'b1, 1'b0, RES_PC4,   BR_JALR, ALU_ADD,   1'b0, 1'b1};
      OP_LUI:    return {1'b0, 1'b1, EXT_U, 1'b0, 1'b0, RES_IMM,   BR_NONE, ALU_ADD,   1'b0, 1'b0};
      OP_AUIPC:  return {1'b0, 1'b1, EXT_U, 1'b0, 1'b0, RES_PCIMM, BR_NONE, ALU_ADD,   1'b0, 1'b0};
      OP_FENCE:  return fence ? 16'h0000 : 16'h8000;
      default:   return 16'h8000;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [12] = '{OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                              OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM, 7'h0B};
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 12);
    if (k < 12) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int popill(input logic [63:0] g, input bit fence);
    logic [15:0] r0, r1;
    r0 = ref_dec(g[31:0], fence);
    r1 = ref_dec(g[63:32], fence);
    return int'(r0[15]) + int'(r1[15]);
  endfunction

  task automatic check_state();
    logic [63:0] g;
    logic [15:0] a0, a1, b0, b1;
    logic [29:0] ec_a, ec_b;
    logic [1:0]  ei_a, ei_b;
    logic        ev, er;
    ec_a = '0; ec_b = '0; ei_a = '0; ei_b = '0;
    ev = (q.size() > 0);
    er = (q.size() < 2);
    if (ev) begin
      g  = q[0];
      a0 = ref_dec(g[31:0], 1'b1);  a1 = ref_dec(g[63:32], 1'b1);
      b0 = ref_dec(g[31:0], 1'b0);  b1 = ref_dec(g[63:32], 1'b0);
      ec_a = {a1[14:0], a0[14:0]};  ei_a = {a1[15], a0[15]};
      ec_b = {b1[14:0], b0[14:0]};  ei_b = {b1[15], b0[15]};
    end
    chk("a_valid", 64'(vld_a), 64'(ev));
    chk("a_ready", 64'(rdy_a), 64'(er));
    chk("a_ctrl",  64'(ctrl_a), 64'(ec_a));
    chk("a_ill",   64'(ill_a), 64'(ei_a));
    chk("a_cnt",   64'(cnt_a), 64'(m_cnt_a));
    chk("b_valid", 64'(vld_b), 64'(ev));
    chk("b_ready", 64'(rdy_b), 64'(er));
    chk("b_ctrl",  64'(ctrl_b), 64'(ec_b));
    chk("b_ill",   64'(ill_b), 64'(ei_b));
    chk("b_cnt",   64'(cnt_b), 64'(m_cnt_b));
  endtask

  // one clock: model steps on the edge, outputs compared on the next negedge
  task automatic tick();
    bit acc, drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && dec_ready;
    @(posedge clk);
    if (drn) begin
      m_cnt_a = m_cnt_a + popill(q[0], 1'b1);
      m_cnt_b = m_cnt_b + popill(q[0], 1'b0);
      if (m_cnt_a > 255) m_cnt_a = 255;
      if (m_cnt_b > 3)   m_cnt_b = 3;
      void'(q.pop_front());
    end
    if (flush)    q.delete();
    else if (acc) q.push_back(instr);
    @(negedge clk);
    check_state();
  endtask

  // asynchronous reset applied mid-cycle; outputs must clear at once
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    m_cnt_a = 0;
    m_cnt_b = 0;
    check_state();
    @(negedge clk);
    reset_n = 1'b1;
    check_state();
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl = '{
      '{32'h00208033, {1'b0, 1'b1, EXT_I, 1'b0, 1'b0, RES_ALU,   BR_NONE, ALU_RTYPE, 1'b0, 1'b0}},
      '{32'h123450B7, {1'b0, 1'b1, EXT_U, 1'b0, 1'b0, RES_IMM,   BR_NONE, ALU_ADD,   1'b0, 1'b0}},
      '{32'h00001117, {1'b0, 1'b1, EXT_U, 1'b0, 1'b0, RES_PCIMM, BR_NONE, ALU_ADD,   1'b0, 1'b0}},
      '{32'h0020A223, {1'b0, 1'b0, EXT_S, 1'b1, 1'b1, RES_ALU,   BR_NONE, ALU_ADD,   1'b1, 1'b0}},
      '{32'h0040A183, {1'b0, 1'b1, EXT_I, 1'b1, 1'b0, RES_MEM,   BR_NONE, ALU_ADD,   1'b1, 1'b0}},
      '{32'h00208463, {1'b0, 1'b0, EXT_B, 1'b0, 1'b0, RES_ALU,   BR_COND, ALU_SUB,   1'b0, 1'b0}},
      '{32'h008000EF, {1'b0, 1'b1, EXT_J, 1'b0, 1'b0, RES_PC4,   BR_JAL,  ALU_ADD,   1'b0, 1'b0}},
      '{32'h000080E7, {1'b0, 1'b1, EXT_I, 1'b1, 1'b0, RES_PC4,   BR_JALR, ALU_ADD,   1'b0, 1'b1}},
      '{32'h00108093, {1'b0, 1'b1, EXT_I, 1'b1, 1'b0, RES_ALU,   BR_NONE, ALU_ITYPE, 1'b0, 1'b0}}
    };

    @(negedge clk);
    do_reset();

    // table stream: one beat per cycle, in order
    dec_ready = 1'b1;
    in_valid  = 1'b1;
    foreach (tbl[i]) begin
      instr = {tbl[i].ins, tbl[i].ins};
      tick();
      chk("tbl_valid", 64'(vld_a), 64'd1);
      chk("tbl_ctrl",  64'(ctrl_a), 64'({tbl[i].exp[14:0], tbl[i].exp[14:0]}));
      chk("tbl_ill",   64'(ill_a), 64'({tbl[i].exp[15], tbl[i].exp[15]}));
    end
    in_valid = 1'b0;
    tick();
    chk("tbl_empty", 64'(vld_a), 64'd0);

    // backpressure: 3 offered, 2 taken, released in order
    dec_ready = 1'b0;
    in_valid  = 1'b1;
    instr = {32'h00000013, 32'h00208033}; tick();
    chk("bp_rdy1", 64'(rdy_a), 64'd1);
    instr = {32'h0040A183, 32'h0020A223}; tick();
    chk("bp_rdy2", 64'(rdy_a), 64'd0);
    instr = {32'h008000EF, 32'h00208463}; tick();
    chk("bp_hold", 64'(ctrl_a[14:0]), 64'(ref_dec(32'h00208033, 1'b1)));
    in_valid  = 1'b0;
    dec_ready = 1'b1;
    repeat (3) tick();
    chk("bp_empty", 64'(vld_a), 64'd0);

    // FENCE / SYSTEM lanes: lane1 = ecall, lane0 = fence
    do_reset();
    in_valid = 1'b1;
    instr = {32'h00000073, 32'h0000000F};
    tick();
    chk("fence_ill_a", 64'(ill_a), 64'b10);
    chk("fence_ill_b", 64'(ill_b), 64'b11);
    chk("fence_ctrl0", 64'(ctrl_a[14:0]), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("fence_cnt_a", 64'(cnt_a), 64'd1);
    chk("fence_cnt_b", 64'(cnt_b), 64'd2);

    // saturation on the 2-bit counter: one illegal lane per group
    do_reset();
    begin
      logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      instr = {32'h00208033, 32'h00000000};
      for (int i = 0; i < 6; i++) begin
        in_valid = (i < 5);
        tick();
        if (i >= 1) chk("sat_cnt_b", 64'(cnt_b), 64'(sat_exp[i-1]));
      end
      chk("sat_cnt_a", 64'(cnt_a), 64'd5);
    end
    in_valid = 1'b0;

    // flush with both entries full and input offered
    dec_ready = 1'b0;
    in_valid  = 1'b1;
    instr = {32'h00000000, 32'h00108093}; tick();
    instr = {32'h00000000, 32'h000080E7}; tick();
    instr = {32'h00000013, 32'h123450B7};
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(vld_a), 64'd0);
    chk("flush_ready", 64'(rdy_a), 64'd1);
    in_valid  = 1'b0;
    dec_ready = 1'b1;
    repeat (2) tick();
    // flush in a drain cycle still counts the drained group
    in_valid = 1'b1;
    instr = {32'h00000000, 32'h00000000}; tick();
    in_valid = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0; tick();

    // randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      in_valid  = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      instr     = {rnd_instr(), rnd_instr()};
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    dec_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
